// File: rtl/load_b_ctrl.sv
// load_b_ctrl: load-side write controller that streams DDR read beats into the B buffer.
// Ports: clk/rst_n (async active-low); inst_valid/inst_ready/inst_buf_addr/inst_len = load command;
// ddr_rdata_valid/ddr_rdata_ready/ddr_rdata/ddr_rdata_last = DDR read beats;
// load_write_addr_valid/load_write_addr/load_write_data = registered buffer write port;
// load_done = one-cycle completion pulse; load_err = sticky length/last mismatch.
// Optional macro LOAD_B_LAST_CHECK_EN enables the ddr_rdata_last vs. count check.
module load_b_ctrl #(
  parameter int BUFFER_ADDR_WIDTH = 9,
  parameter int BUFFER_DATA_WIDTH = 512,
  parameter int LEN_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         inst_valid,
  output logic                         inst_ready,
  input  logic [BUFFER_ADDR_WIDTH-1:0] inst_buf_addr,
  input  logic [LEN_WIDTH-1:0]         inst_len,
  input  logic                         ddr_rdata_valid,
  output logic                         ddr_rdata_ready,
  input  logic [BUFFER_DATA_WIDTH-1:0] ddr_rdata,
  input  logic                         ddr_rdata_last,
  output logic                         load_write_addr_valid,
  output logic [BUFFER_ADDR_WIDTH-1:0] load_write_addr,
  output logic [BUFFER_DATA_WIDTH-1:0] load_write_data,
  output logic                         load_done,
  output logic                         load_err
);
  typedef enum logic {IDLE, LOAD} state_t;
  state_t state, state_nxt;
  logic [BUFFER_ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0] remain;
  logic accept, beat, last_beat;
  assign inst_ready = state == IDLE;
  assign ddr_rdata_ready = state == LOAD;
  assign accept = inst_valid && inst_ready;
  assign beat = ddr_rdata_valid && ddr_rdata_ready;
  assign last_beat = beat && remain == LEN_WIDTH'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // a zero-length command completes without leaving IDLE
  always_comb begin
    state_nxt = state;
    state_nxt = (accept && inst_len != '0) ? LOAD : last_beat ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur_addr <= '0;
      remain <= '0;
      load_write_addr_valid <= 1'b0;
      load_write_addr <= '0;
      load_write_data <= '0;
      load_done <= 1'b0;
    end else begin
      if (accept) begin
        cur_addr <= inst_buf_addr;
        remain <= inst_len;
      end else if (beat) begin
        cur_addr <= cur_addr + 1'b1;
        remain <= remain - 1'b1;
      end
      load_write_addr_valid <= beat;
      load_write_addr <= beat ? cur_addr : '0;
      load_write_data <= beat ? ddr_rdata : '0;
      load_done <= (accept && inst_len == '0) || last_beat;
    end
`ifdef LOAD_B_LAST_CHECK_EN
  // last flag is advisory only: completion is always by count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) load_err <= 1'b0;
    else if (beat && (ddr_rdata_last != (remain == LEN_WIDTH'(1)))) load_err <= 1'b1;
`else
  logic unused_last;
  assign unused_last = ddr_rdata_last;
  assign load_err = 1'b0;
`endif
endmodule

// File: tb/tb_load_b_ctrl.sv
// tb_load_b_ctrl: directed and randomized checks of load_b_ctrl against a line-count model.
module tb_load_b_ctrl;
  localparam int AW = 9;
  localparam int DW = 512;
  localparam int LW = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inst_valid = 1'b0;
  logic inst_ready;
  logic [AW-1:0] inst_buf_addr = '0;
  logic [LW-1:0] inst_len = '0;
  logic ddr_rdata_valid = 1'b0;
  logic ddr_rdata_ready;
  logic [DW-1:0] ddr_rdata = '0;
  logic ddr_rdata_last = 1'b0;
  logic load_write_addr_valid;
  logic [AW-1:0] load_write_addr;
  logic [DW-1:0] load_write_data;
  logic load_done;
  logic load_err;
  int checks = 0;
  int failures = 0;
  bit m_busy = 0;
  bit m_err = 0;
  int m_base = 0;
  int m_len = 0;
  int m_k = 0;
  always #5 clk = ~clk;
  load_b_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_buf_addr(inst_buf_addr), .inst_len(inst_len),
    .ddr_rdata_valid(ddr_rdata_valid), .ddr_rdata_ready(ddr_rdata_ready),
    .ddr_rdata(ddr_rdata), .ddr_rdata_last(ddr_rdata_last),
    .load_write_addr_valid(load_write_addr_valid), .load_write_addr(load_write_addr),
    .load_write_data(load_write_data), .load_done(load_done), .load_err(load_err)
  );
  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction
  function automatic bit is_last();
    return m_busy && (m_k == m_len - 1);
  endfunction
  task automatic check_idle_outputs(string tag);
    chk({tag, "_wv"}, load_write_addr_valid, 0);
    chk({tag, "_wa"}, load_write_addr, 0);
    chk({tag, "_wd"}, load_write_data, 0);
    chk({tag, "_done"}, load_done, 0);
    chk({tag, "_err"}, load_err, 0);
    chk({tag, "_iready"}, inst_ready, 1);
    chk({tag, "_dready"}, ddr_rdata_ready, 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    inst_valid = 1'b0;
    ddr_rdata_valid = 1'b0;
    #1;
    check_idle_outputs("reset");
    m_busy = 0;
    m_err = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic cycle(bit iv, int ia, int il, bit dv, bit dl, logic [DW-1:0] dd);
    bit acc, bt, e_done;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;
    inst_valid = iv;
    inst_buf_addr = AW'(ia);
    inst_len = LW'(il);
    ddr_rdata_valid = dv;
    ddr_rdata_last = dl;
    ddr_rdata = dd;
    chk("inst_ready", inst_ready, !m_busy);
    chk("ddr_ready", ddr_rdata_ready, m_busy);
    acc = iv && !m_busy;
    bt = dv && m_busy;
    e_wa = bt ? AW'((m_base + m_k) % (1 << AW)) : '0;
    e_wd = bt ? dd : '0;
    e_done = 0;
    if (bt) begin
`ifdef LOAD_B_LAST_CHECK_EN
      if (dl != (m_k == m_len - 1)) m_err = 1;
`endif
      m_k++;
      if (m_k == m_len) begin
        m_busy = 0;
        e_done = 1;
      end
    end else if (acc) begin
      m_base = ia;
      m_len = il;
      m_k = 0;
      m_busy = il != 0;
      e_done = il == 0;
    end
    @(posedge clk);
    #1;
    chk("write_valid", load_write_addr_valid, bt);
    chk("write_addr", load_write_addr, e_wa);
    chk("write_data", load_write_data, e_wd);
    chk("done", load_done, e_done);
    chk("err", load_err, m_err);
  endtask
  initial begin
    bit dl;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("por");
    rst_n = 1'b1;
    cycle(1, 5, 4, 0, 0, '0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, is_last(), rnd_data());
    cycle(0, 0, 0, 0, 0, '0);
    cycle(1, 510, 3, 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, is_last(), rnd_data());
    cycle(1, 77, 0, 1, 0, rnd_data());
    cycle(0, 0, 0, 1, 0, rnd_data());
    cycle(1, 20, 4, 0, 0, '0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, i % 2 == 0, is_last(), rnd_data());
    cycle(1, 100, 6, 0, 0, '0);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, 0, rnd_data());
    do_reset();
    cycle(1, 0, 1, 0, 0, '0);
    cycle(0, 0, 0, 1, 1, rnd_data());
    cycle(1, 500, 520, 0, 0, '0);
    for (int i = 0; i < 520; i++) cycle(0, 0, 0, 1, is_last(), rnd_data());
    cycle(1, 30, 3, 0, 0, '0);
    cycle(0, 0, 0, 1, 0, rnd_data());
    cycle(0, 0, 0, 1, 1, rnd_data());
    cycle(0, 0, 0, 1, 0, rnd_data());
    cycle(0, 0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, 0, '0);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      dl = is_last() ^ ($urandom_range(0, 19) == 0);
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 511), $urandom_range(0, 6),
            $urandom_range(0, 3) != 0, dl, rnd_data());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
